// File: rtl/rotor_cipher_path.sv
// rotor_cipher_path: sequential Enigma I letter path (rotors III/II/I, reflector B).
// Accepts one letter, requests one rotor step, waits a settle cycle, then walks the
// letter forward through three rotors, the reflector and back, one lookup per clock.
module rotor_cipher_path (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] char_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       step_req,
  input  logic [4:0] rotor1_pos,
  input  logic [4:0] rotor2_pos,
  input  logic [4:0] rotor3_pos,
  output logic [4:0] char_out,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_SETTLE, S_F1, S_F2, S_F3, S_RF, S_B3, S_B2, S_B1, S_DONE
  } state_t;

  // Wiring tables (A=0 .. Z=25). Inverse tables are precomputed so the backward
  // pass is a single lookup rather than a search.
  localparam logic [4:0] ROT3_FWD [26] = '{  // rotor III, fastest
    5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam logic [4:0] ROT3_INV [26] = '{
    5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
    5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
  localparam logic [4:0] ROT2_FWD [26] = '{  // rotor II
    5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
    5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  localparam logic [4:0] ROT2_INV [26] = '{
    5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
  localparam logic [4:0] ROT1_FWD [26] = '{  // rotor I, slowest
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  localparam logic [4:0] ROT1_INV [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
    5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
  localparam logic [4:0] REFL_B [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  state_t     state_reg;
  logic [4:0] x_reg;

  logic [4:0] pos_raw [3];
  logic [4:0] pos_red [3];
  logic [4:0] pos_sel;
  logic [5:0] sum_ext;
  logic [4:0] entry_idx;
  logic [4:0] wire_out;
  logic [5:0] diff_ext;
  logic [4:0] stage_out;

  assign pos_raw[0] = rotor1_pos;
  assign pos_raw[1] = rotor2_pos;
  assign pos_raw[2] = rotor3_pos;

  // Out-of-range positions (26..31) are folded back into 0..25 before use.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pos_reduce
      assign pos_red[gi] = (pos_raw[gi] >= 5'd26) ? (pos_raw[gi] - 5'd26) : pos_raw[gi];
    end
  endgenerate

  assign in_ready = (state_reg == S_IDLE) && !rst;

  // One rotor stage: enter at (x+p) mod 26, look up the wiring, leave at (w-p) mod 26.
  always_comb begin
    pos_sel = 5'd0;
    case (state_reg)
      S_F1, S_B1: pos_sel = pos_red[0];
      S_F2, S_B2: pos_sel = pos_red[1];
      S_F3, S_B3: pos_sel = pos_red[2];
      default:    pos_sel = 5'd0;
    endcase

    sum_ext = {1'b0, x_reg} + {1'b0, pos_sel};
    if (sum_ext >= 6'd26) begin
      sum_ext = sum_ext - 6'd26;
    end
    entry_idx = sum_ext[4:0];

    wire_out = 5'd0;
    case (state_reg)
      S_F1:    wire_out = ROT3_FWD[entry_idx];
      S_F2:    wire_out = ROT2_FWD[entry_idx];
      S_F3:    wire_out = ROT1_FWD[entry_idx];
      S_B3:    wire_out = ROT1_INV[entry_idx];
      S_B2:    wire_out = ROT2_INV[entry_idx];
      S_B1:    wire_out = ROT3_INV[entry_idx];
      default: wire_out = 5'd0;
    endcase

    // A negative difference shows up as bit 5 set; adding 26 brings it back into range.
    diff_ext = {1'b0, wire_out} - {1'b0, pos_sel};
    if (diff_ext[5]) begin
      diff_ext = diff_ext + 6'd26;
    end
    stage_out = diff_ext[4:0];
  end

  // Transaction sequencer: accept, step, settle, seven lookups, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      x_reg     <= 5'd0;
      char_out  <= 5'd0;
      out_valid <= 1'b0;
      step_req  <= 1'b0;
    end else begin
      step_req <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= char_in;
            if (char_in >= 5'd26) begin
              // Not a letter: pass it through untouched and do not step the rotors.
              char_out  <= char_in;
              out_valid <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              step_req  <= 1'b1;
              state_reg <= S_STEP;
            end
          end
        end
        S_STEP:   state_reg <= S_SETTLE;
        S_SETTLE: state_reg <= S_F1;
        S_F1: begin
          x_reg     <= stage_out;
          state_reg <= S_F2;
        end
        S_F2: begin
          x_reg     <= stage_out;
          state_reg <= S_F3;
        end
        S_F3: begin
          x_reg     <= stage_out;
          state_reg <= S_RF;
        end
        S_RF: begin
          x_reg     <= REFL_B[x_reg];
          state_reg <= S_B3;
        end
        S_B3: begin
          x_reg     <= stage_out;
          state_reg <= S_B2;
        end
        S_B2: begin
          x_reg     <= stage_out;
          state_reg <= S_B1;
        end
        S_B1: begin
          x_reg     <= stage_out;
          char_out  <= stage_out;
          out_valid <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
